chirp_phase_gen: RTL and testbench

//  Generates the LoRa chirp phase sequence (pi factored out, full circle = 2^PRECISION) that drives

---
 rtl/chirp_phase_gen.sv | 117 +++++++++++
 tb/tb_chirp_phase_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/chirp_phase_gen.sv
// LoRa chirp phase generator: a per-symbol up/down frequency ramp with cyclic wrap,
// integrated into a phase accumulator that stays continuous across symbols and idle gaps.
module chirp_phase_gen #(
  parameter int PRECISION = 16,
  parameter int SF        = 7,
  parameter int OSR_LOG2  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_en,
  input  logic                 sym_valid,
  output logic                 sym_ready,
  input  logic [SF-1:0]        sym_value,
  input  logic                 sym_down,
  output logic [PRECISION-1:0] angle,
  output logic                 angle_valid,
  output logic                 sym_first,
  output logic                 sym_last
);

  localparam int CW      = SF + OSR_LOG2;
  localparam int FW      = PRECISION + 2;
  localparam int S_SHIFT = PRECISION - SF - OSR_LOG2;

  localparam logic signed [FW-1:0] ONE_C    = {{(FW-1){1'b0}}, 1'b1};
  localparam logic signed [FW-1:0] H_C      = ONE_C << (PRECISION - 1 - OSR_LOG2);
  localparam logic signed [FW-1:0] TWO_H_C  = ONE_C << (PRECISION - OSR_LOG2);
  localparam logic signed [FW-1:0] STEP_C   = ONE_C << (PRECISION - SF - 2 * OSR_LOG2);
  localparam logic [CW-1:0]        LAST_C   = {CW{1'b1}};
  localparam logic [CW-1:0]        CNT_ONE_C = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state_r;
  logic [PRECISION-1:0]   phase_r;
  // One guard bit above the PRECISION+1 signed range keeps the ramp arithmetic overflow-free.
  logic signed [FW-1:0]   freq_r;
  logic [CW-1:0]          cnt_r;
  logic                   dir_r;
  logic                   angle_valid_r;

  logic                   accept_s;
  logic signed [FW-1:0]   freq_step_s;
  logic signed [FW-1:0]   freq_next_s;
  logic signed [FW-1:0]   bin_s;
  logic signed [FW-1:0]   freq_load_s;

  assign sym_ready   = !rst && ((state_r == IDLE) ||
                                ((state_r == RUN) && sample_en && (cnt_r == LAST_C)));
  assign accept_s    = sym_valid && sym_ready;
  assign angle       = phase_r;
  assign angle_valid = angle_valid_r;
  assign sym_first   = (state_r == RUN) && (cnt_r == {CW{1'b0}});
  assign sym_last    = (state_r == RUN) && (cnt_r == LAST_C);

  // Next ramp frequency with cyclic wrap, and the start frequency of a newly accepted symbol.
  always_comb begin
    freq_step_s = freq_r;
    freq_next_s = freq_r;
    bin_s       = {{(FW-SF){1'b0}}, sym_value} << S_SHIFT;
    if (dir_r) begin
      freq_step_s = freq_r - STEP_C;
      if (freq_step_s < -H_C) begin
        freq_next_s = freq_step_s + TWO_H_C;
      end else begin
        freq_next_s = freq_step_s;
      end
    end else begin
      freq_step_s = freq_r + STEP_C;
      if (freq_step_s >= H_C) begin
        freq_next_s = freq_step_s - TWO_H_C;
      end else begin
        freq_next_s = freq_step_s;
      end
    end
    if (sym_down) begin
      freq_load_s = H_C - bin_s;
    end else begin
      freq_load_s = bin_s - H_C;
    end
  end

  // Symbol sequencing, phase accumulation and frequency ramp.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      phase_r       <= '0;
      freq_r        <= '0;
      cnt_r         <= '0;
      dir_r         <= 1'b0;
      angle_valid_r <= 1'b0;
    end else begin
      // An accept while running can only happen on the final advancing sample.
      if ((state_r == RUN) && sample_en) begin
        phase_r <= phase_r + freq_r[PRECISION-1:0];
      end
      if (accept_s) begin
        state_r       <= RUN;
        cnt_r         <= '0;
        dir_r         <= sym_down;
        freq_r        <= freq_load_s;
        angle_valid_r <= 1'b1;
      end else if ((state_r == RUN) && sample_en) begin
        cnt_r  <= cnt_r + CNT_ONE_C;
        freq_r <= freq_next_s;
        if (cnt_r == LAST_C) begin
          state_r       <= IDLE;
          angle_valid_r <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_chirp_phase_gen.sv
// Bench for chirp_phase_gen: a closed-form chirp model (frequency of sample k computed directly
// from symbol value and direction) checked against the DUT every cycle, plus literal anchors.
module tb_chirp_phase_gen;

  localparam int P    = 16;
  localparam int SFP  = 7;
  localparam int OSR  = 0;
  localparam int M    = 1 << (SFP + OSR);
  localparam int H    = 1 << (P - 1 - OSR);
  localparam int S    = 1 << (P - SFP - OSR);
  localparam int STEP = 1 << (P - SFP - 2 * OSR);
  localparam int MASK = (1 << P) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           sample_en;
  logic           sym_valid;
  logic           sym_ready;
  logic [SFP-1:0] sym_value;
  logic           sym_down;
  logic [P-1:0]   angle;
  logic           angle_valid;
  logic           sym_first;
  logic           sym_last;

  always #5 clk = ~clk;

  chirp_phase_gen #(.PRECISION(P), .SF(SFP), .OSR_LOG2(OSR)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .sym_value(sym_value), .sym_down(sym_down),
    .angle(angle), .angle_valid(angle_valid), .sym_first(sym_first), .sym_last(sym_last)
  );

  int checks = 0;
  int errors = 0;

  bit m_active;
  int m_phase;
  int m_k;
  int m_v;
  bit m_down;
  int m_accepts;
  int cap[M];

  // Frequency of sample k: the up ramp starts at -H + v*S and wraps in [-H, H);
  // the down ramp is its mirror in (-H, H].
  function automatic int mfreq(int v, bit down, int k);
    int u;
    u = (v * S + k * STEP) % (2 * H);
    return down ? (H - u) : (u - H);
  endfunction

  task automatic cmp(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_outputs();
    int er;
    er = (!rst && (!m_active || (sample_en && m_k == M - 1))) ? 1 : 0;
    cmp("sym_ready", int'(sym_ready), er);
    cmp("angle_valid", int'(angle_valid), int'(m_active));
    cmp("angle", int'(angle), m_phase);
    cmp("sym_first", int'(sym_first), (m_active && m_k == 0) ? 1 : 0);
    cmp("sym_last", int'(sym_last), (m_active && m_k == M - 1) ? 1 : 0);
    if (m_active) cap[m_k] = int'(angle);
  endtask

  task automatic model_update();
    bit acc;
    if (rst) begin
      m_active = 1'b0;
      m_phase  = 0;
      m_k      = 0;
    end else begin
      acc = sym_valid && (!m_active || (sample_en && m_k == M - 1));
      if (m_active && sample_en) begin
        m_phase = (m_phase + mfreq(m_v, m_down, m_k)) & MASK;
        m_k++;
        if (m_k == M) m_active = 1'b0;
      end
      if (acc) begin
        m_active = 1'b1;
        m_k      = 0;
        m_v      = int'(sym_value);
        m_down   = sym_down;
        m_accepts++;
      end
    end
  endtask

  // One clock: drive at the falling edge, check after settling, update the model at the rising edge.
  task automatic step(bit r, bit en, bit v, int val, bit d);
    rst       = r;
    sample_en = en;
    sym_valid = v;
    sym_value = val[SFP-1:0];
    sym_down  = d;
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset(int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'($urandom), 1'($urandom), int'($urandom), 1'($urandom));
  endtask

  task automatic send(int v, bit d, int period);
    int cyc;
    cyc = 0;
    step(1'b0, 1'b0, 1'b1, v, d);
    while (m_active && cyc < M * period + 8) begin
      step(1'b0, (cyc % period) == 0, 1'b0, int'($urandom), 1'($urandom));
      cyc++;
    end
    if (m_active) begin
      errors++;
      $display("FAIL send_timeout: symbol %0d still running after %0d cycles", v, cyc);
    end
    step(1'b0, 1'b1, 1'b0, 0, 1'b0);
  endtask

  initial begin
    int n;
    int n_valid;
    int base;
    rst = 1'b1; sample_en = 1'b0; sym_valid = 1'b0; sym_value = '0; sym_down = 1'b0;
    m_active = 1'b0; m_phase = 0; m_k = 0; m_v = 0; m_down = 1'b0; m_accepts = 0;
    @(negedge clk);

    do_reset(3);
    cmp("rst_angle", int'(angle), 0);
    cmp("rst_valid", int'(angle_valid), 0);

    // Upchirp, symbol 0: no wrap, ends half a circle away.
    send(0, 1'b0, 1);
    cmp("up0_s1", cap[1], 32768);
    cmp("up0_s2", cap[2], 512);
    cmp("up0_end", int'(angle), 32768);

    // Upchirp, symbol 64: starts at zero frequency and wraps mid-symbol.
    do_reset(1);
    send(64, 1'b0, 1);
    cmp("up64_s2", cap[2], 512);
    cmp("up64_end", int'(angle), 32768);

    // Downchirp, symbol 0.
    do_reset(1);
    send(0, 1'b1, 1);
    cmp("dn0_s1", cap[1], 32768);
    cmp("dn0_s2", cap[2], 65024);
    cmp("dn0_end", int'(angle), 32768);

    // Two symbols with sym_valid held: second accept on the last sample, no idle gap.
    do_reset(1);
    base = m_accepts;
    n = 0;
    n_valid = 0;
    while (((m_accepts - base) < 2 || m_active) && n < 400) begin
      n_valid += int'(angle_valid);
      step(1'b0, 1'b1, (m_accepts - base) < 2, (m_accepts == base) ? 5 : 9, 1'b0);
      n++;
    end
    cmp("b2b_live_samples", n_valid, 2 * M);

    // Sample strobe 1-in-4: same sequence, held between strobes.
    do_reset(1);
    send(0, 1'b0, 4);
    cmp("slow_s2", cap[2], 512);
    cmp("slow_end", int'(angle), 32768);

    // Reset in the middle of a symbol, then a clean restart.
    do_reset(1);
    step(1'b0, 1'b0, 1'b1, 3, 1'b0);
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 0, 1'b0);
    cmp("midrst_angle", int'(angle), 0);
    cmp("midrst_valid", int'(angle_valid), 0);
    send(7, 1'b1, 1);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 113) == 0, ($urandom % 3) != 0, ($urandom % 4) == 0,
           int'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
